// File: rtl/cdb_arbiter.sv
// Result-bus arbiter: per-lane result FIFOs drained round-robin onto a registered CDB.
// Enqueue-to-broadcast latency is two cycles; a lane is ready only while its queue is not full.
`ifndef WAY
`define WAY 2
`endif

package cdb_pkg;
   typedef struct packed {
      logic        valid;
      logic [5:0]  phy_dest_reg;
      logic [31:0] result;
      logic [4:0]  rob_index;
   } result_packet_t;
endpackage

module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int CDB_WIDTH = `WAY,
   parameter int DEPTH     = 2
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                flush,
   input  result_packet_t [N_SRC-1:0]          fu_result,
   output logic [N_SRC-1:0]                    src_ready,
   output result_packet_t [CDB_WIDTH-1:0]      cdb,
   output logic [$clog2(N_SRC*DEPTH+1)-1:0]    pending
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int TW = $clog2(N_SRC * DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   result_packet_t                 mem [N_SRC][DEPTH];
   logic [CW-1:0]                  count [N_SRC];
   logic [CW-1:0]                  count_d [N_SRC];
   logic [PW-1:0]                  head [N_SRC];
   logic [PW-1:0]                  tail [N_SRC];
   logic [SW-1:0]                  rr_ptr;
   logic [SW-1:0]                  rr_d;
   logic [N_SRC-1:0]               grant;
   logic [N_SRC-1:0]               push;
   result_packet_t [CDB_WIDTH-1:0] cdb_q;
   result_packet_t [CDB_WIDTH-1:0] cdb_d;
   logic [TW-1:0]                  total_d;
   logic                           clear;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign clear = reset | flush;

   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         src_ready[i] = (count[i] < FULL);
         push[i]      = fu_result[i].valid & src_ready[i];
      end
   end

   // Scan from rr_ptr using start-of-cycle counts; the k-th nonempty queue fills slot k.
   always_comb begin
      int slot;
      int idx;
      grant = '0;
      cdb_d = '0;
      rr_d  = rr_ptr;
      slot  = 0;
      idx   = 0;
      for (int k = 0; k < N_SRC; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_SRC) idx = idx - N_SRC;
         if (count[idx] != '0 && slot < CDB_WIDTH) begin
            grant[idx]        = 1'b1;
            cdb_d[slot]       = mem[idx][head[idx]];
            cdb_d[slot].valid = 1'b1;
            rr_d              = (idx == N_SRC - 1) ? '0 : SW'(idx + 1);
            slot              = slot + 1;
         end
      end
   end

   always_comb begin
      total_d = '0;
      for (int i = 0; i < N_SRC; i++) begin
         count_d[i] = count[i] + CW'(push[i]) - CW'(grant[i]);
         total_d    = total_d + TW'(count_d[i]);
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < N_SRC; i++) begin
         if (push[i]) mem[i][tail[i]] <= fu_result[i];
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < N_SRC; i++) begin
            count[i] <= '0;
            head[i]  <= '0;
            tail[i]  <= '0;
         end
         rr_ptr  <= '0;
         cdb_q   <= '0;
         pending <= '0;
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            count[i] <= count_d[i];
            if (push[i])  tail[i] <= ptr_inc(tail[i]);
            if (grant[i]) head[i] <= ptr_inc(head[i]);
         end
         rr_ptr  <= rr_d;
         cdb_q   <= cdb_d;
         pending <= total_d;
      end
   end

   // A squash must not let last cycle's grants reach the ROB.
   assign cdb = clear ? '0 : cdb_q;

endmodule
